// File: rtl/vector_mem_reader.sv
// Walks a word-addressed range of the vector data memory and serialises each
// vecSize-lane word onto a valid/ready byte stream, lane 0 first.
module vector_mem_reader #(
  parameter int unsigned vecSize        = 4,
  parameter int unsigned dataSize       = 8,
  parameter int unsigned addressingSize = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [addressingSize-1:0]           baseAddr,
  input  logic [addressingSize-1:0]           wordCount,
  output logic                                memReadEn,
  output logic [addressingSize-1:0]           memAddr,
  input  logic [vecSize-1:0][dataSize-1:0]    memReadData,
  output logic [dataSize-1:0]                 outByte,
  output logic                                outValid,
  input  logic                                outReady,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned LaneW = (vecSize > 1) ? $clog2(vecSize) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(vecSize - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StSend,
    StFinish
  } state_e;

  state_e                             state_q, state_d;
  logic [addressingSize-1:0]          addr_q, addr_d;
  logic [addressingSize-1:0]          remaining_q, remaining_d;
  logic [LaneW-1:0]                   lane_q, lane_d;
  logic [vecSize-1:0][dataSize-1:0]   buf_q, buf_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    lane_d      = lane_q;
    buf_d       = buf_q;
    memReadEn   = 1'b0;
    memAddr     = '0;
    outValid    = 1'b0;
    outByte     = '0;
    busy        = (state_q != StIdle);
    done        = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          addr_d      = baseAddr;
          remaining_d = wordCount;
          lane_d      = '0;
          state_d     = (wordCount == '0) ? StFinish : StFetch;
        end
      end
      StFetch: begin
        memReadEn   = 1'b1;
        memAddr     = addr_q;
        remaining_d = remaining_q - 1'b1;
        state_d     = StCapture;
      end
      StCapture: begin
        buf_d   = memReadData;
        lane_d  = '0;
        state_d = StSend;
      end
      StSend: begin
        outValid = 1'b1;
        outByte  = buf_q[lane_q];
        if (outReady) begin
          lane_d = lane_q + 1'b1;
          // remaining was already decremented in FETCH, so zero means last word
          if (lane_q == LastLane) begin
            if (remaining_q == '0) begin
              state_d = StFinish;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = StFetch;
            end
          end
        end
      end
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      lane_q      <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      lane_q      <= lane_d;
      buf_q       <= buf_d;
    end
  end

endmodule

// File: tb/tb_vector_mem_reader.sv
// Scoreboard bench for vector_mem_reader: expected addresses and bytes are queued
// at start and consumed by a negedge monitor as the DUT emits them.
module tb_vector_mem_reader;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [15:0]       baseAddr;
  logic [15:0]       wordCount;
  logic              memReadEn;
  logic [15:0]       memAddr;
  logic [3:0][7:0]   memReadData;
  logic [7:0]        outByte;
  logic              outValid;
  logic              outReady;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_addrs[$];

  int n_bytes = 0;
  int n_reads = 0;
  int n_done = 0;
  int n_stall = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int mark_bytes = 0;
  int first_xfer_cyc = 0;

  vector_mem_reader #(
    .vecSize       (4),
    .dataSize      (8),
    .addressingSize(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .baseAddr   (baseAddr),
    .wordCount  (wordCount),
    .memReadEn  (memReadEn),
    .memAddr    (memAddr),
    .memReadData(memReadData),
    .outByte    (outByte),
    .outValid   (outValid),
    .outReady   (outReady),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [7:0] b;
    if (a == 16'h0010) return 32'h44332211;
    b = a[7:0] + {a[11:8], a[15:12]} + 8'h01;
    return {b ^ 8'hC3, b ^ 8'h96, b ^ 8'h5A, b ^ 8'h2D};
  endfunction

  // Memory answers one cycle after the strobe; garbage otherwise exposes mistimed capture.
  always @(posedge clk) memReadData <= memReadEn ? mem_word(memAddr) : 32'($urandom);

  task automatic monitor();
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic [7:0] eb;
    logic [15:0] ea;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        n_stall++;
        checks++;
        if (!(outValid === 1'b1 && outByte === prev_byte)) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b byte=%h, want valid=1 byte=%h",
                   outValid, outByte, prev_byte);
        end
      end
      if (memReadEn === 1'b1) begin
        n_reads++;
        checks++;
        if (exp_addrs.size() == 0) begin
          errors++;
          $display("FAIL read_addr: got unexpected read at %h, want no read", memAddr);
        end else begin
          ea = exp_addrs.pop_front();
          if (memAddr !== ea) begin
            errors++;
            $display("FAIL read_addr: got %h, want %h", memAddr, ea);
          end
        end
      end
      if (outValid === 1'b1 && outReady === 1'b1) begin
        if (n_bytes == mark_bytes) first_xfer_cyc = cyc;
        n_bytes++;
        checks++;
        if (exp_bytes.size() == 0) begin
          errors++;
          $display("FAIL out_byte: got unexpected byte %h, want none", outByte);
        end else begin
          eb = exp_bytes.pop_front();
          if (outByte !== eb) begin
            errors++;
            $display("FAIL out_byte: got %h, want %h", outByte, eb);
          end
        end
      end
      if (done === 1'b1) begin
        n_done++;
        done_cyc = cyc;
      end
      prev_stall = (outValid === 1'b1) && (outReady !== 1'b1);
      prev_byte  = outByte;
    end
  endtask

  task automatic kick(input logic [15:0] base, input logic [15:0] cnt);
    logic [15:0] a;
    logic [31:0] w;
    mark_bytes = n_bytes;
    @(posedge clk); #1;
    baseAddr = base;
    wordCount = cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0;
    baseAddr = 16'($urandom);
    wordCount = 16'($urandom);
    a = base;
    for (int i = 0; i < int'(cnt); i++) begin
      exp_addrs.push_back(a);
      w = mem_word(a);
      for (int l = 0; l < 4; l++) exp_bytes.push_back(w[8*l +: 8]);
      a = a + 16'd1;
    end
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 400 && n_done == d0; i++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({memReadEn, memAddr, outByte, outValid, busy, done} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b addr=%h byte=%h valid=%b busy=%b done=%b, want all 0",
               memReadEn, memAddr, outByte, outValid, busy, done);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({memReadEn, memAddr, outValid, busy, done} !== 20'd0) begin
      errors++;
      $display("FAIL idle_outputs: got en=%b addr=%h valid=%b busy=%b done=%b, want all 0",
               memReadEn, memAddr, outValid, busy, done);
    end
  endtask

  task automatic test_single_word();
    int d0 = n_done;
    int r0 = n_reads;
    outReady = 1'b1;
    kick(16'h0010, 16'd1);
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: got %b, want 1", busy);
    end
    wait_done(d0);
    checks++;
    if (n_done != d0 + 1) begin
      errors++;
      $display("FAIL single_done: got %0d done pulses, want 1", n_done - d0);
    end
    checks++;
    if (done_cyc - start_cyc != 6 || first_xfer_cyc - start_cyc != 2) begin
      errors++;
      $display("FAIL single_timing: got done +%0d first byte +%0d, want +6 and +2",
               done_cyc - start_cyc, first_xfer_cyc - start_cyc);
    end
    checks++;
    if (n_reads - r0 != 1 || exp_bytes.size() != 0) begin
      errors++;
      $display("FAIL single_count: got %0d reads %0d bytes left, want 1 and 0",
               n_reads - r0, exp_bytes.size());
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_multi_word();
    int d0 = n_done;
    int r0 = n_reads;
    kick(16'h0100, 16'd3);
    wait_done(d0);
    checks++;
    if (n_done != d0 + 1 || done_cyc - start_cyc != 18) begin
      errors++;
      $display("FAIL multi_timing: got %0d pulses at +%0d, want 1 at +18",
               n_done - d0, done_cyc - start_cyc);
    end
    checks++;
    if (n_reads - r0 != 3 || exp_bytes.size() != 0 || exp_addrs.size() != 0) begin
      errors++;
      $display("FAIL multi_count: got %0d reads %0d bytes left, want 3 and 0",
               n_reads - r0, exp_bytes.size());
    end
  endtask

  task automatic test_backpressure();
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int d0 = n_done;
    int s0 = n_stall;
    int b0 = n_bytes;
    kick(16'h0040, 16'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      outReady = pat[i];
    end
    @(posedge clk); #1;
    outReady = 1'b1;
    wait_done(d0);
    checks++;
    if (n_done != d0 + 1 || done_cyc - start_cyc != 9) begin
      errors++;
      $display("FAIL bp_timing: got %0d pulses at +%0d, want 1 at +9",
               n_done - d0, done_cyc - start_cyc);
    end
    checks++;
    if (n_bytes - b0 != 4 || n_stall - s0 != 3 || exp_bytes.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got %0d bytes %0d stalls, want 4 and 3",
               n_bytes - b0, n_stall - s0);
    end
  endtask

  task automatic test_wrap();
    int d0 = n_done;
    int r0 = n_reads;
    int b0 = n_bytes;
    kick(16'hFFFF, 16'd2);
    wait_done(d0);
    checks++;
    if (n_done != d0 + 1 || done_cyc - start_cyc != 12) begin
      errors++;
      $display("FAIL wrap_timing: got %0d pulses at +%0d, want 1 at +12",
               n_done - d0, done_cyc - start_cyc);
    end
    checks++;
    if (n_reads - r0 != 2 || n_bytes - b0 != 8 || exp_addrs.size() != 0) begin
      errors++;
      $display("FAIL wrap_count: got %0d reads %0d bytes, want 2 and 8",
               n_reads - r0, n_bytes - b0);
    end
  endtask

  task automatic test_zero_and_ignored_start();
    int d0 = n_done;
    int r0 = n_reads;
    int b0;
    kick(16'h0200, 16'd0);
    wait_done(d0);
    checks++;
    if (n_done != d0 + 1 || done_cyc - start_cyc != 0 || n_reads != r0) begin
      errors++;
      $display("FAIL zero_count: got %0d pulses at +%0d with %0d reads, want 1 at +0, 0 reads",
               n_done - d0, done_cyc - start_cyc, n_reads - r0);
    end
    d0 = n_done;
    r0 = n_reads;
    b0 = n_bytes;
    kick(16'h0300, 16'd2);
    repeat (3) @(posedge clk);
    #1;
    baseAddr = 16'h0500;
    wordCount = 16'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0);
    checks++;
    if (n_done != d0 + 1 || done_cyc - start_cyc != 12) begin
      errors++;
      $display("FAIL ignore_start_timing: got %0d pulses at +%0d, want 1 at +12",
               n_done - d0, done_cyc - start_cyc);
    end
    checks++;
    if (n_reads - r0 != 2 || n_bytes - b0 != 8 || exp_bytes.size() != 0) begin
      errors++;
      $display("FAIL ignore_start_count: got %0d reads %0d bytes, want 2 and 8",
               n_reads - r0, n_bytes - b0);
    end
  endtask

  task automatic test_reset_mid();
    int d0 = n_done;
    int b0 = n_bytes;
    kick(16'h0030, 16'd2);
    for (int i = 0; i < 100 && n_bytes < b0 + 2; i++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (n_bytes != b0 + 2) begin
      errors++;
      $display("FAIL rst_mid_progress: got %0d bytes, want 2", n_bytes - b0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    outReady = 1'b0;
    @(negedge clk); #1;
    exp_bytes.delete();
    exp_addrs.delete();
    @(negedge clk); #1;
    checks++;
    if ({memReadEn, memAddr, outByte, outValid, busy, done} !== 28'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got en=%b addr=%h byte=%h valid=%b busy=%b done=%b, want 0",
               memReadEn, memAddr, outByte, outValid, busy, done);
    end
    reset = 1'b0;
    outReady = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (n_done != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_done: got %0d pulses busy=%b, want 0 pulses busy=0",
               n_done - d0, busy);
    end
    b0 = n_bytes;
    kick(16'h0020, 16'd1);
    wait_done(d0);
    checks++;
    if (n_done != d0 + 1 || done_cyc - start_cyc != 6 || n_bytes - b0 != 4) begin
      errors++;
      $display("FAIL rst_mid_rerun: got %0d pulses at +%0d %0d bytes, want 1 at +6, 4 bytes",
               n_done - d0, done_cyc - start_cyc, n_bytes - b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    outReady = 1'b1;
    baseAddr = '0;
    wordCount = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_word();
    test_multi_word();
    test_backpressure();
    test_wrap();
    test_zero_and_ignored_start();
    test_reset_mid();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_bytes.size() != 0 || exp_addrs.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d bytes %0d addrs pending, want 0 0",
               exp_bytes.size(), exp_addrs.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_mem_reader.md
# vector_mem_reader

Streams a contiguous region of the vector data memory out of the processor, one byte per handshake. It is the read-side counterpart of the writeback stage's memory writes: writeback stores 4-lane byte vectors into data memory, and this block walks a programmed address range, fetches each vector word and serialises its lanes onto a valid/ready byte stream. Typical consumers are a host dump port and a result-export FIFO. The block shares the data memory read port, with address and enable muxing done outside.

## Interface
Parameters:
- vecSize, 4, lanes per memory word (bytes emitted per word)
- dataSize, 8, bits per lane / output byte width
- addressingSize, 16, memory address width (word-addressed)

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request a transfer; sampled only in IDLE
- baseAddr  input  addressingSize  first word address, latched on accepted start
- wordCount  input  addressingSize  number of words to stream, latched on accepted start
- memReadEn  output  1  read strobe to data memory
- memAddr  output  addressingSize  read address to data memory
- memReadData  input  [vecSize-1:0][dataSize-1:0]  memory read data, valid the cycle after memReadEn
- outByte  output  dataSize  streamed byte
- outValid  output  1  outByte is valid
- outReady  input  1  consumer accepts outByte this cycle
- busy  output  1  high in every state except IDLE
- done  output  1  single-cycle pulse when the transfer completes

## Operation
- States: IDLE, FETCH, CAPTURE, SEND, FINISH.
- IDLE: start=1 latches baseAddr into the address register, wordCount into the remaining counter and goes to FETCH. If wordCount=0, it goes directly to FINISH with no memory access. start is ignored in every other state.
- FETCH: memReadEn=1, memAddr=address register, remaining decremented. Next state is CAPTURE.
- CAPTURE: memReadData is registered into a vecSize-byte buffer, lane counter cleared. Next state is SEND.
- SEND: outValid=1 and outByte=buffer[lane], lane 0 first.
  - A transfer occurs when outValid and outReady are both high. The lane counter then increments.
  - On the transfer of lane vecSize-1: if remaining=0, go to FINISH. Otherwise increment the address by 1 and go to FETCH.
  - Without a transfer, outByte and outValid hold unchanged (no drop, no duplicate).
- FINISH: done=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^addressingSize: 0xFFFF+1 wraps to 0x0000 and continues.
- memAddr reads 0 whenever memReadEn=0.
- Reset in any state returns to IDLE, clears the buffer, counters and address, and discards any partially sent word.

## Timing
- Reset values: memReadEn=0, memAddr=0, outByte=0, outValid=0, busy=0, done=0.
- Start accepted at edge t:
  - FETCH in cycle t+1 (memReadEn=1).
  - CAPTURE in cycle t+2 (memReadData sampled at the end of this cycle).
  - First outValid in cycle t+3.
- With outReady held high, a word costs 2+vecSize cycles (6 for vecSize=4), and the next FETCH follows the cycle after the last lane transfer.
- The last lane transfer at edge u gives done=1 in cycle u+1 and busy=0 in cycle u+2. start is accepted again at edge u+2.
- wordCount=0: done=1 in cycle t+1 with no memReadEn pulse.
- busy rises in the cycle after start is accepted and stays high through FINISH.

## Test plan
- Single word: mem[0x0010]={0x44,0x33,0x22,0x11} (lane3..0), start with base=0x0010, count=1, outReady=1.
  - Expect exactly one memReadEn pulse at addr 0x0010.
  - Expect bytes 0x11,0x22,0x33,0x44 in cycles t+3..t+6, then done in t+7.
- Multi-word throughput: base=0x0100, count=3, outReady=1.
  - Expect memAddr 0x0100, 0x0101, 0x0102 in order.
  - Expect 12 bytes in lane order, done 19 cycles after start.
- Backpressure: toggle outReady 1,0,0,1,0,1 during SEND.
  - outByte must stay stable while stalled.
  - All 4 bytes are delivered once each, in order.
- Wrap-around: base=0xFFFF, count=2. Expect reads at 0xFFFF then 0x0000, and 8 bytes.
- Zero count and ignored start: start with count=0 gives a done pulse in t+1 and no memReadEn. A start pulsed mid-SEND has no effect on the addresses or byte count.
- Reset mid-operation: assert reset while in SEND after 2 bytes.
  - All outputs return to reset values the next cycle.
  - No done pulse.
  - A subsequent start with base=0x0020, count=1 runs normally.
